rs_bank: RTL and testbench

- Parametrised single-class reservation-station bank; one instance per functional-unit class (ALU, MULT, LOAD, STORE, BRANCH), sitting between dispatch and the issue/FU stage.
- Holds up to DEPTH RS_PACKETs and wakes source operands from NUM_CDB parallel CDB broadcasts, including a same-cycle bypass into allocation.
- Each cycle, selects the oldest fully-ready entry and offers it over a valid/ready issue handshake.
- Supports whole-bank flush on mispredict and exposes occupancy counters.

---
 rtl/rs_bank_pkg.sv | 37 +++
 rtl/rs_bank_if.sv | 36 +++
 rtl/rs_age_matrix.sv | 45 ++++
 rtl/rs_bank.sv | 147 ++++++++++++++
 tb/tb_rs_bank.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_bank_pkg.sv
// Shared types for the reservation-station banks: packet layout, PREG operand, FU classes.
package rs_bank_pkg;

  localparam int unsigned PREG_IDX_W    = 6;
  localparam int unsigned NUM_CDB_PORTS = 2;

  // Default bank depths per functional-unit class.
  localparam int unsigned RS_DEPTH_ALU    = 8;
  localparam int unsigned RS_DEPTH_MULT   = 4;
  localparam int unsigned RS_DEPTH_LOAD   = 8;
  localparam int unsigned RS_DEPTH_STORE  = 8;
  localparam int unsigned RS_DEPTH_BRANCH = 4;

  typedef enum logic [2:0] {
    FuAlu,
    FuMult,
    FuLoad,
    FuStore,
    FuBranch
  } funit_e;

  // Physical register operand: index plus "value available" flag.
  typedef struct packed {
    logic [PREG_IDX_W-1:0] tag;
    logic                  ready;
  } preg_t;

  typedef struct packed {
    funit_e                funit;
    logic [7:0]            op;
    logic [PREG_IDX_W-1:0] dest_tag;
    preg_t                 src1_reg;
    preg_t                 src2_reg;
    logic [15:0]           imm;
  } rs_packet_t;

endpackage

// File: rtl/rs_bank_if.sv
// Dispatch / CDB / issue bundle between a reservation-station bank and its neighbours.
interface rs_bank_if
  import rs_bank_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NUM_CDB = NUM_CDB_PORTS,
  parameter int unsigned TAG_W   = PREG_IDX_W
) ();

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                            alloc_valid;
  rs_packet_t                      alloc_packet;
  logic                            alloc_ready;
  logic [NUM_CDB-1:0]              cdb_valid;
  logic [NUM_CDB-1:0][TAG_W-1:0]   cdb_tag;
  logic                            issue_valid;
  rs_packet_t                      issue_packet;
  logic                            issue_ready;
  logic [CntW-1:0]                 free_count;
  logic                            full;
  logic                            empty;

  // Dispatch / CDB / FU side.
  modport master (
    output alloc_valid, alloc_packet, cdb_valid, cdb_tag, issue_ready,
    input  alloc_ready, issue_valid, issue_packet, free_count, full, empty
  );

  // Reservation-station bank side.
  modport slave (
    input  alloc_valid, alloc_packet, cdb_valid, cdb_tag, issue_ready,
    output alloc_ready, issue_valid, issue_packet, free_count, full, empty
  );

endinterface

// File: rtl/rs_age_matrix.sv
// Age matrix: tracks relative order of live entries and picks the oldest candidate.
// older_q[i][j] = 1 means entry j was allocated before entry i and is still live.
module rs_age_matrix #(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic [DEPTH-1:0] alloc_onehot_i,
  input  logic [DEPTH-1:0] free_onehot_i,
  input  logic [DEPTH-1:0] valid_i,
  input  logic [DEPTH-1:0] cand_i,
  output logic [DEPTH-1:0] oldest_onehot_o
);

  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

  // Next matrix: clear columns of freed/reused slots, then stamp the new row.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < DEPTH; i++) begin
      older_d[i] = older_d[i] & ~(alloc_onehot_i | free_onehot_i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      // An entry leaving this same cycle must not be recorded as older.
      if (alloc_onehot_i[i]) older_d[i] = valid_i & ~free_onehot_i;
    end
    if (flush_i) older_d = '0;
  end

  // Matrix register.
  always_ff @(posedge clock) begin
    if (reset) older_q <= '0;
    else       older_q <= older_d;
  end

  // A candidate wins when no older entry is also a candidate.
  always_comb begin
    oldest_onehot_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      oldest_onehot_o[i] = cand_i[i] & ~(|(older_q[i] & cand_i));
    end
  end

endmodule

// File: rtl/rs_bank.sv
// Single-class reservation-station bank: entry storage, CDB wakeup with allocation
// bypass, oldest-ready select over a valid/ready issue handshake, flush and occupancy.
module rs_bank
  import rs_bank_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NUM_CDB = NUM_CDB_PORTS,
  // Must equal PREG_IDX_W, the tag width carried inside rs_packet_t.
  parameter int unsigned TAG_W   = PREG_IDX_W
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   flush_i,
  rs_bank_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]       valid_q, valid_d;
  rs_packet_t [DEPTH-1:0] pkt_q, pkt_d;
  logic [CntW-1:0]        free_count_q, free_count_d;

  logic [DEPTH-1:0] free_slot_onehot;
  logic [DEPTH-1:0] alloc_onehot;
  logic [DEPTH-1:0] free_onehot;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] oldest_onehot;
  logic             alloc_ready;
  logic             alloc_fire;
  logic             issue_valid;
  logic             issue_fire;
  rs_packet_t       alloc_pkt;
  rs_packet_t       issue_pkt;

  function automatic logic cdb_hit(input logic [TAG_W-1:0]              tag,
                                   input logic [NUM_CDB-1:0]            vld,
                                   input logic [NUM_CDB-1:0][TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_CDB; p++) begin
      hit = hit | (vld[p] & (tags[p] == tag));
    end
    return hit;
  endfunction

  // Lowest-index invalid slot.
  always_comb begin
    free_slot_onehot = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_slot_onehot = DEPTH'(1) << i;
    end
  end

  // Handshake qualifiers; alloc_ready depends on registered state only.
  always_comb begin
    alloc_ready  = (free_count_q != '0);
    alloc_fire   = bus.alloc_valid & alloc_ready & ~flush_i;
    alloc_onehot = alloc_fire ? free_slot_onehot : '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = valid_q[i] & pkt_q[i].src1_reg.ready & pkt_q[i].src2_reg.ready;
    end
    issue_valid = (|cand) & ~flush_i;
    issue_fire  = issue_valid & bus.issue_ready;
    free_onehot = issue_fire ? oldest_onehot : '0;
  end

  rs_age_matrix #(
    .DEPTH(DEPTH)
  ) u_age (
    .clock          (clock),
    .reset          (reset),
    .flush_i        (flush_i),
    .alloc_onehot_i (alloc_onehot),
    .free_onehot_i  (free_onehot),
    .valid_i        (valid_q),
    .cand_i         (cand),
    .oldest_onehot_o(oldest_onehot)
  );

  // Incoming packet with same-cycle CDB bypass applied to its sources.
  always_comb begin
    alloc_pkt = bus.alloc_packet;
    if (cdb_hit(alloc_pkt.src1_reg.tag, bus.cdb_valid, bus.cdb_tag)) begin
      alloc_pkt.src1_reg.ready = 1'b1;
    end
    if (cdb_hit(alloc_pkt.src2_reg.tag, bus.cdb_valid, bus.cdb_tag)) begin
      alloc_pkt.src2_reg.ready = 1'b1;
    end
  end

  // Next entry state: wakeup, issue release, allocation, then flush override.
  always_comb begin
    valid_d      = valid_q;
    pkt_d        = pkt_q;
    free_count_d = free_count_q - CntW'(alloc_fire) + CntW'(issue_fire);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        if (cdb_hit(pkt_q[i].src1_reg.tag, bus.cdb_valid, bus.cdb_tag)) begin
          pkt_d[i].src1_reg.ready = 1'b1;
        end
        if (cdb_hit(pkt_q[i].src2_reg.tag, bus.cdb_valid, bus.cdb_tag)) begin
          pkt_d[i].src2_reg.ready = 1'b1;
        end
      end
    end
    valid_d = valid_d & ~free_onehot;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_onehot[i]) begin
        valid_d[i] = 1'b1;
        pkt_d[i]   = alloc_pkt;
      end
    end
    if (flush_i) begin
      valid_d      = '0;
      free_count_d = CntW'(DEPTH);
    end
  end

  // Entry and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= '0;
      pkt_q        <= '0;
      free_count_q <= CntW'(DEPTH);
    end else begin
      valid_q      <= valid_d;
      pkt_q        <= pkt_d;
      free_count_q <= free_count_d;
    end
  end

  // Issue packet mux driven by the one-hot oldest candidate; zero when none.
  always_comb begin
    issue_pkt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (oldest_onehot[i]) issue_pkt = pkt_q[i];
    end
  end

  assign bus.alloc_ready  = alloc_ready;
  assign bus.issue_valid  = issue_valid;
  assign bus.issue_packet = issue_pkt;
  assign bus.free_count   = free_count_q;
  assign bus.full         = (free_count_q == '0);
  assign bus.empty        = (free_count_q == CntW'(DEPTH));

endmodule

// File: tb/tb_rs_bank.sv
// Self-checking bench for rs_bank (DEPTH=4, NUM_CDB=2): per-cycle vector table plus an
// issue scoreboard, with hand-written reset sequences around it.
module tb_rs_bank;
  import rs_bank_pkg::*;

  localparam int unsigned D = 4;

  logic clock = 1'b0;
  logic reset;
  logic flush_i;

  always #5 clock = ~clock;

  rs_bank_if #(.DEPTH(D), .NUM_CDB(2), .TAG_W(6)) rs_if ();

  rs_bank #(
    .DEPTH  (D),
    .NUM_CDB(2),
    .TAG_W  (6)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .flush_i(flush_i),
    .bus    (rs_if)
  );

  typedef struct {
    logic       fl;
    logic       av;
    int         id;
    int         t1;
    logic       r1;
    int         t2;
    logic       r2;
    logic [1:0] cv;
    int         ct0;
    int         ct1;
    logic       ir;
    logic       eiv;
    int         eid;
    int         efc;
  } vec_t;

  vec_t       vecs[$];
  rs_packet_t exp_q[$];
  rs_packet_t pkt_by_id[256];
  rs_packet_t got_p;
  int         n_vec  = 0;
  int         n_err  = 0;
  int         n_viol = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rs_packet_t mk_pkt(input int id, input int t1, input logic r1,
                                        input int t2, input logic r2);
    rs_packet_t p;
    p.funit          = funit_e'(3'(id % 5));
    p.op             = 8'(id);
    p.dest_tag       = 6'(id + 20);
    p.src1_reg.tag   = 6'(t1);
    p.src1_reg.ready = r1;
    p.src2_reg.tag   = 6'(t2);
    p.src2_reg.ready = r2;
    p.imm            = {8'(id), ~8'(id)};
    return p;
  endfunction

  task automatic add(input logic fl, input logic av, input int id, input int t1,
                     input logic r1, input int t2, input logic r2, input logic [1:0] cv,
                     input int ct0, input int ct1, input logic ir, input logic eiv,
                     input int eid, input int efc);
    vec_t v;
    v.fl = fl;   v.av = av;   v.id = id;   v.t1 = t1;   v.r1 = r1;  v.t2 = t2;  v.r2 = r2;
    v.cv = cv;   v.ct0 = ct0; v.ct1 = ct1; v.ir = ir;   v.eiv = eiv; v.eid = eid;
    v.efc = efc;
    vecs.push_back(v);
  endtask

  task automatic idle();
    flush_i               = 1'b0;
    rs_if.alloc_valid     = 1'b0;
    rs_if.alloc_packet    = '0;
    rs_if.cdb_valid       = '0;
    rs_if.cdb_tag[0]      = '0;
    rs_if.cdb_tag[1]      = '0;
    rs_if.issue_ready     = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    rs_packet_t p;
    flush_i            = v.fl;
    rs_if.alloc_valid  = v.av;
    rs_if.alloc_packet = mk_pkt(v.id, v.t1, v.r1, v.t2, v.r2);
    rs_if.cdb_valid    = v.cv;
    rs_if.cdb_tag[0]   = 6'(v.ct0);
    rs_if.cdb_tag[1]   = 6'(v.ct1);
    rs_if.issue_ready  = v.ir;
    if (v.av) pkt_by_id[v.id] = mk_pkt(v.id, v.t1, v.r1, v.t2, v.r2);
    // Expected handshake this cycle: queue the packet the FU should receive.
    if (v.eiv && v.ir && !v.fl) begin
      p                = pkt_by_id[v.eid];
      p.src1_reg.ready = 1'b1;
      p.src2_reg.ready = 1'b1;
      exp_q.push_back(p);
    end
  endtask

  task automatic check_row(input int n, input vec_t v);
    check($sformatf("r%0d issue_valid", n), 64'(rs_if.issue_valid), 64'(v.eiv));
    if (v.eiv) begin
      check($sformatf("r%0d issue_id", n), 64'(rs_if.issue_packet.op), 64'(v.eid));
      check($sformatf("r%0d issue_rdy", n),
            64'({rs_if.issue_packet.src1_reg.ready, rs_if.issue_packet.src2_reg.ready}),
            64'(2'b11));
    end
    check($sformatf("r%0d free_count", n), 64'(rs_if.free_count), 64'(v.efc));
    check($sformatf("r%0d alloc_ready", n), 64'(rs_if.alloc_ready), 64'(v.efc != 0));
    check($sformatf("r%0d full", n), 64'(rs_if.full), 64'(v.efc == 0));
    check($sformatf("r%0d empty", n), 64'(rs_if.empty), 64'(v.efc == int'(D)));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " issue_valid"}, 64'(rs_if.issue_valid), 64'(0));
    check({tag, " issue_packet"}, 64'(rs_if.issue_packet), 64'(0));
    check({tag, " free_count"}, 64'(rs_if.free_count), 64'(D));
    check({tag, " alloc_ready"}, 64'(rs_if.alloc_ready), 64'(1));
    check({tag, " full"}, 64'(rs_if.full), 64'(0));
    check({tag, " empty"}, 64'(rs_if.empty), 64'(1));
  endtask

  // Scoreboard: every completed handshake must match the next queued packet.
  always @(negedge clock) begin
    if (!reset && rs_if.issue_valid && rs_if.issue_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_issue: got op %0d, expected no issue (t=%0t)",
                 rs_if.issue_packet.op, $time);
      end else begin
        got_p = exp_q.pop_front();
        check("issue_packet", 64'(rs_if.issue_packet), 64'(got_p));
      end
    end
    if (!reset && rs_if.alloc_valid && rs_if.full) n_viol++;
  end

  initial begin
    // Columns: fl av id t1 r1 t2 r2 cv ct0 ct1 ir | eiv eid efc
    // Single ready packet: visible next cycle, slot back after issue.
    add(0, 1,  1,  1, 1,  2, 1, 2'b00,  0,  0, 1,  0,  0, 4);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  1,  1, 3);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  0,  0, 4);
    // B waits on tag 5, C ready; C goes first, then B after CDB port 1.
    add(0, 1,  2,  5, 0,  3, 1, 2'b00,  0,  0, 0,  0,  0, 4);
    add(0, 1,  3,  1, 1,  2, 1, 2'b00,  0,  0, 0,  0,  0, 3);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  1,  3, 2);
    add(0, 0,  0,  0, 0,  0, 0, 2'b10,  0,  5, 0,  0,  0, 3);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  1,  2, 3);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 0,  0,  0, 4);
    // Older E woken after newer F is offered: E takes over.
    add(0, 1,  4,  7, 0,  3, 1, 2'b00,  0,  0, 0,  0,  0, 4);
    add(0, 1,  5,  1, 1,  2, 1, 2'b00,  0,  0, 0,  0,  0, 3);
    add(0, 0,  0,  0, 0,  0, 0, 2'b01,  7,  0, 0,  1,  5, 2);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 0,  1,  4, 2);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  1,  4, 2);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  1,  5, 3);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 0,  0,  0, 4);
    // Fill, push while full (ignored), drain.
    add(0, 1,  6, 10, 0,  3, 1, 2'b00,  0,  0, 0,  0,  0, 4);
    add(0, 1,  7, 11, 0,  3, 1, 2'b00,  0,  0, 0,  0,  0, 3);
    add(0, 1,  8, 12, 0,  3, 1, 2'b00,  0,  0, 0,  0,  0, 2);
    add(0, 1,  9, 13, 0,  3, 1, 2'b00,  0,  0, 0,  0,  0, 1);
    add(0, 1, 10,  1, 1,  2, 1, 2'b00,  0,  0, 0,  0,  0, 0);
    add(0, 1, 10,  1, 1,  2, 1, 2'b01, 12,  0, 0,  0,  0, 0);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  1,  8, 0);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 0,  0,  0, 1);
    add(0, 0,  0,  0, 0,  0, 0, 2'b11, 10, 11, 0,  0,  0, 1);
    add(0, 0,  0,  0, 0,  0, 0, 2'b01, 13,  0, 1,  1,  6, 1);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  1,  7, 2);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  1,  9, 3);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 0,  0,  0, 4);
    // Allocation-cycle bypass on port 0, then on both ports at once.
    add(0, 1, 11,  1, 1,  9, 0, 2'b01,  9,  0, 0,  0,  0, 4);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  1, 11, 3);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 0,  0,  0, 4);
    add(0, 1, 12, 15, 0, 16, 0, 2'b11, 16, 15, 0,  0,  0, 4);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  1, 12, 3);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 0,  0,  0, 4);
    // Flush with allocation and issue pending; stale wakeups afterwards.
    add(0, 1, 13,  1, 1,  2, 1, 2'b00,  0,  0, 0,  0,  0, 4);
    add(0, 1, 14, 20, 0,  3, 1, 2'b00,  0,  0, 0,  1, 13, 3);
    add(0, 1, 15, 21, 0,  3, 1, 2'b00,  0,  0, 0,  1, 13, 2);
    add(1, 1, 16,  1, 1,  2, 1, 2'b00,  0,  0, 1,  0,  0, 1);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  0,  0, 4);
    add(0, 0,  0,  0, 0,  0, 0, 2'b11, 20, 21, 1,  0,  0, 4);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  0,  0, 4);
    // Backpressure: newer-ready entry must not displace the offered one.
    add(0, 1, 17,  1, 1,  2, 1, 2'b00,  0,  0, 0,  0,  0, 4);
    add(0, 1, 18, 22, 0,  3, 1, 2'b00,  0,  0, 0,  1, 17, 3);
    add(0, 0,  0,  0, 0,  0, 0, 2'b01, 22,  0, 0,  1, 17, 2);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 0,  1, 17, 2);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 0,  1, 17, 2);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  1, 17, 2);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  1, 18, 3);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 0,  0,  0, 4);
    // Allocate and issue in the same cycle.
    add(0, 1, 19,  1, 1,  2, 1, 2'b00,  0,  0, 0,  0,  0, 4);
    add(0, 1, 20,  1, 1,  2, 1, 2'b00,  0,  0, 1,  1, 19, 3);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 1,  1, 20, 3);
    add(0, 0,  0,  0, 0,  0, 0, 2'b00,  0,  0, 0,  0,  0, 4);

    // Power-up reset.
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_state("reset");

    foreach (vecs[n]) begin
      @(posedge clock);
      #1 drive(vecs[n]);
      @(negedge clock);
      check_row(n, vecs[n]);
    end

    // Reset asserted with a ready entry resident.
    @(posedge clock);
    #1 idle();
    rs_if.alloc_valid  = 1'b1;
    rs_if.alloc_packet = mk_pkt(30, 1, 1'b1, 2, 1'b1);
    @(posedge clock);
    #1 idle();
    reset = 1'b1;
    @(negedge clock);
    check("midreset before free_count", 64'(rs_if.free_count), 64'(D - 1));
    check("midreset before issue_id", 64'(rs_if.issue_packet.op), 64'(30));
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_state("midreset");

    @(posedge clock);
    #1;
    check("scoreboard drained", 64'(exp_q.size()), 64'(0));
    check("alloc_while_full seen", 64'(n_viol), 64'(2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
